// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the serial N-channel stereo audio mixer.
// Width helper and the generic saturator live here so sub-blocks agree on sizing.
package audio_mixer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SAT   = 2'd2
   } mix_state_e;

   // Saturator operand width; wide enough for any accumulator shifted to OUT_WIDTH.
   localparam int SAT_MAX_W = 64;

   function automatic int acc_width(input int num_ch, input int in_w, input int gain_w);
      return in_w + gain_w + $clog2(num_ch) + 1;
   endfunction

   function automatic logic signed [SAT_MAX_W-1:0] saturate(
      input logic signed [SAT_MAX_W-1:0] value,
      input int                          width
   );
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      else
         return value;
   endfunction

endpackage

// File: rtl/audio_mixer_mac.sv
// Single-channel sign conversion and gain scaling; time-shared by the mixer
// across all channels, one channel per clock.
module audio_mixer_mac
   import audio_mixer_pkg::*;
#(
   parameter int IN_WIDTH   = 16,
   parameter int GAIN_WIDTH = 8
) (
   input  logic [IN_WIDTH-1:0]                  sample,
   input  logic                                 is_signed,
   input  logic [GAIN_WIDTH-1:0]                gain,
   output logic signed [IN_WIDTH+GAIN_WIDTH:0]  product
);

   logic signed [IN_WIDTH-1:0]            s;
   logic signed [GAIN_WIDTH:0]            g;
   logic signed [IN_WIDTH+GAIN_WIDTH:0]   full;

   // Offset-binary becomes two's complement by flipping the MSB.
   always_comb begin
      s       = is_signed ? sample : {~sample[IN_WIDTH-1], sample[IN_WIDTH-2:0]};
      g       = {1'b0, gain};
      full    = s * g;
      product = full >>> (GAIN_WIDTH - 1);
   end

endmodule

// File: rtl/audio_mixer.sv
// N-channel stereo mixer: snapshot on sample tick, serial gain/route accumulate,
// then saturate to the output width with sticky clip and overrun flags.
module audio_mixer
   import audio_mixer_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int IN_WIDTH     = 16,
   parameter int OUT_WIDTH    = 16,
   parameter int GAIN_WIDTH   = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               sample_strobe_i,
   input  logic [NUM_CHANNELS*IN_WIDTH-1:0]   ch_data_i,
   input  logic [NUM_CHANNELS-1:0]            ch_signed_i,
   input  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] ch_gain_i,
   input  logic [NUM_CHANNELS-1:0]            ch_left_en_i,
   input  logic [NUM_CHANNELS-1:0]            ch_right_en_i,
   input  logic                               mute_i,
   input  logic                               clear_flags_i,
   output logic [OUT_WIDTH-1:0]               audio_l_o,
   output logic [OUT_WIDTH-1:0]               audio_r_o,
   output logic                               valid_o,
   output logic                               busy_o,
   output logic                               clip_l_o,
   output logic                               clip_r_o,
   output logic                               overrun_o
);

   localparam int ACC_W = acc_width(NUM_CHANNELS, IN_WIDTH, GAIN_WIDTH);
   localparam int P_W   = IN_WIDTH + GAIN_WIDTH + 1;
   localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   mix_state_e                  state;
   mix_state_e                  next_state;
   logic [IDX_W-1:0]            idx;
   logic [IN_WIDTH-1:0]         snap_data [NUM_CHANNELS];
   logic [GAIN_WIDTH-1:0]       snap_gain [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]     snap_sgn;
   logic [NUM_CHANNELS-1:0]     snap_l;
   logic [NUM_CHANNELS-1:0]     snap_r;
   logic signed [ACC_W-1:0]     acc_l;
   logic signed [ACC_W-1:0]     acc_r;
   logic signed [P_W-1:0]       prod;
   logic signed [SAT_MAX_W-1:0] sat_in_l;
   logic signed [SAT_MAX_W-1:0] sat_in_r;
   logic signed [SAT_MAX_W-1:0] sat_l;
   logic signed [SAT_MAX_W-1:0] sat_r;
   logic                        accept;
   logic                        last_ch;
   logic                        clip_l_set;
   logic                        clip_r_set;

   assign accept  = (state == IDLE) && sample_strobe_i;
   assign last_ch = (idx == IDX_W'(NUM_CHANNELS - 1));
   assign busy_o  = (state != IDLE);

   audio_mixer_mac #(
      .IN_WIDTH   (IN_WIDTH),
      .GAIN_WIDTH (GAIN_WIDTH)
   ) u_mac (
      .sample    (snap_data[idx]),
      .is_signed (snap_sgn[idx]),
      .gain      (snap_gain[idx]),
      .product   (prod)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sample_strobe_i) next_state = ACCUM;
         ACCUM:   if (last_ch) next_state = SAT;
         SAT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Snapshot is pure data: only loaded on an accepted tick, never reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            snap_data[k] <= ch_data_i[k*IN_WIDTH +: IN_WIDTH];
            snap_gain[k] <= ch_gain_i[k*GAIN_WIDTH +: GAIN_WIDTH];
         end
         snap_sgn <= ch_signed_i;
         snap_l   <= ch_left_en_i;
         snap_r   <= ch_right_en_i;
      end
   end

   always_comb begin
      sat_in_l   = SAT_MAX_W'(acc_l) <<< (OUT_WIDTH - IN_WIDTH);
      sat_in_r   = SAT_MAX_W'(acc_r) <<< (OUT_WIDTH - IN_WIDTH);
      sat_l      = saturate(sat_in_l, OUT_WIDTH);
      sat_r      = saturate(sat_in_r, OUT_WIDTH);
      clip_l_set = (state == SAT) && !mute_i && (sat_l != sat_in_l);
      clip_r_set = (state == SAT) && !mute_i && (sat_r != sat_in_r);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx       <= '0;
         acc_l     <= '0;
         acc_r     <= '0;
         audio_l_o <= '0;
         audio_r_o <= '0;
         valid_o   <= 1'b0;
         clip_l_o  <= 1'b0;
         clip_r_o  <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_strobe_i) begin
                  acc_l <= '0;
                  acc_r <= '0;
                  idx   <= '0;
               end
            end
            ACCUM: begin
               if (snap_l[idx]) acc_l <= acc_l + ACC_W'(prod);
               if (snap_r[idx]) acc_r <= acc_r + ACC_W'(prod);
               idx <= idx + 1'b1;
            end
            SAT: begin
               audio_l_o <= mute_i ? '0 : sat_l[OUT_WIDTH-1:0];
               audio_r_o <= mute_i ? '0 : sat_r[OUT_WIDTH-1:0];
               valid_o   <= 1'b1;
            end
            default: ;
         endcase
         // Set terms are OR-ed after the clear so a coincident event is kept.
         overrun_o <= (overrun_o & ~clear_flags_i) | (sample_strobe_i & busy_o);
         clip_l_o  <= (clip_l_o & ~clear_flags_i) | clip_l_set;
         clip_r_o  <= (clip_r_o & ~clear_flags_i) | clip_r_set;
      end
   end

endmodule
